status_flags_ctrl: RTL and testbench

STATUS_FLAGS_CTRL -- requirements
Module: status_flags_ctrl

---
 rtl/status_flags_ctrl.sv | 90 +++++++++
 tb/tb_status_flags_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/status_flags_ctrl.sv
// Command/status handshake between the HPS PIOs and a coprocessor: issues a
// one-cycle start strobe and reports DONE/ERROR/BUSY/TIMEOUT as registered flags.
module status_flags_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       core_done,
  input  logic       core_error,
  output logic       start_pulse,
  output logic [3:0] flags
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] FLAGS_DONE    = 4'b0001;
  localparam logic [3:0] FLAGS_ERROR   = 4'b0010;
  localparam logic [3:0] FLAGS_BUSY    = 4'b0100;
  localparam logic [3:0] FLAGS_TIMEOUT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cmd_q;
  logic             start_pulse_reg;
  logic [3:0]       flags_reg;
  logic             rise;

  assign rise        = cmd_valid & ~cmd_q;
  assign start_pulse = start_pulse_reg;
  assign flags       = flags_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      cmd_q           <= 1'b0;
      start_pulse_reg <= 1'b0;
      flags_reg       <= 4'b0000;
    end else begin
      cmd_q           <= cmd_valid;
      start_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Outcome flags from the previous operation stay visible until a new start.
          if (rise) begin
            state_reg       <= RUN;
            start_pulse_reg <= 1'b1;
            flags_reg       <= FLAGS_BUSY;
            cnt_reg         <= '0;
          end
        end
        RUN: begin
          // Priority: error, then done, then budget exhaustion.
          if (core_error) begin
            state_reg <= FAULT;
            flags_reg <= FLAGS_ERROR;
          end else if (core_done) begin
            state_reg <= DONE;
            flags_reg <= FLAGS_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= FAULT;
            flags_reg <= FLAGS_TIMEOUT;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        DONE, FAULT: begin
          // The host must drop cmd_valid before another rise can be accepted.
          if (!cmd_valid) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_flags_ctrl.sv
// Directed scenarios plus a random phase, every cycle compared against an
// operation-level reference model of the command/status handshake.
module tb_status_flags_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       core_done;
  logic       core_error;
  logic       start_pulse;
  logic [3:0] flags;

  always #5 clk = ~clk;

  status_flags_ctrl #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .core_done  (core_done),
    .core_error (core_error),
    .start_pulse(start_pulse),
    .flags      (flags)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: an operation is either in progress (m_busy) or finished
  // with an outcome (0 none, 1 done, 2 error, 3 timeout); m_hold waits for the
  // host to drop cmd_valid after completion.
  bit m_prev;
  bit m_busy;
  bit m_hold;
  bit m_start;
  int m_elapsed;
  int m_outcome;

  function automatic logic [3:0] model_flags();
    return {(m_outcome == 3), m_busy, (m_outcome == 2), (m_outcome == 1)};
  endfunction

  task automatic model_step();
    bit rise;
    if (reset) begin
      m_prev = 0; m_busy = 0; m_hold = 0; m_start = 0;
      m_elapsed = 0; m_outcome = 0;
    end else begin
      rise    = cmd_valid && !m_prev;
      m_prev  = cmd_valid;
      m_start = 0;
      if (m_busy) begin
        if (core_error) begin
          m_busy = 0; m_hold = 1; m_outcome = 2;
        end else if (core_done) begin
          m_busy = 0; m_hold = 1; m_outcome = 1;
        end else if (m_elapsed + 1 == T) begin
          m_busy = 0; m_hold = 1; m_outcome = 3;
        end else begin
          m_elapsed++;
        end
      end else if (m_hold) begin
        if (!cmd_valid) m_hold = 0;
      end else if (rise) begin
        m_busy = 1; m_start = 1; m_outcome = 0; m_elapsed = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the inputs present at the edge, outputs
  // are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_start", {3'b000, start_pulse}, {3'b000, m_start});
    check("model_flags", flags, model_flags());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; core_done = 1'b0; core_error = 1'b0;
    ticks(3);
    check("reset_flags", flags, 4'b0000);
    check("reset_start", {3'b000, start_pulse}, 4'b0000);
    reset = 1'b0;
    ticks(3);

    // Basic start / done / release
    cmd_valid = 1'b1; tick();
    check("basic_start", {3'b000, start_pulse}, 4'b0001);
    check("basic_busy", flags, 4'b0100);
    tick();
    check("basic_start_once", {3'b000, start_pulse}, 4'b0000);
    ticks(8);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("basic_done", flags, 4'b0001);
    ticks(3);
    cmd_valid = 1'b0; tick(); tick();
    check("basic_idle_sticky", flags, 4'b0001);
    $display("step basic: flags=%b", flags);

    // Timeout after exactly T RUN cycles; late core_done ignored
    cmd_valid = 1'b1; tick();
    for (int i = 0; i < T - 1; i++) begin
      tick();
      check("timeout_still_busy", flags, 4'b0100);
    end
    tick();
    check("timeout_fire", flags, 4'b1000);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("timeout_late_done", flags, 4'b1000);
    cmd_valid = 1'b0; ticks(2);
    $display("step timeout: flags=%b", flags);

    // Collision: error beats done
    cmd_valid = 1'b1; tick(); ticks(3);
    core_done = 1'b1; core_error = 1'b1; tick();
    core_done = 1'b0; core_error = 1'b0;
    check("collision_err", flags, 4'b0010);
    cmd_valid = 1'b0; ticks(2);

    // Done on the final budget cycle beats timeout
    cmd_valid = 1'b1; tick(); ticks(T - 1);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("last_cycle_done", flags, 4'b0001);
    cmd_valid = 1'b0; ticks(2);
    $display("step collision: flags=%b", flags);

    // Rise during RUN ignored, counter keeps running
    cmd_valid = 1'b1; tick(); ticks(2);
    cmd_valid = 1'b0; tick();
    cmd_valid = 1'b1; tick();
    check("ignored_rise_start", {3'b000, start_pulse}, 4'b0000);
    check("ignored_rise_busy", flags, 4'b0100);
    ticks(T - 5);
    check("ignored_rise_still_busy", flags, 4'b0100);
    tick();
    check("ignored_rise_timeout", flags, 4'b1000);
    cmd_valid = 1'b0; ticks(2);
    $display("step ignored_rise: flags=%b", flags);

    // Sticky ERROR cleared by the next start
    cmd_valid = 1'b1; tick(); tick();
    core_error = 1'b1; tick(); core_error = 1'b0;
    check("sticky_err", flags, 4'b0010);
    cmd_valid = 1'b0; tick(); tick();
    check("sticky_err_idle", flags, 4'b0010);
    cmd_valid = 1'b1; tick();
    check("sticky_restart_flags", flags, 4'b0100);
    check("sticky_restart_start", {3'b000, start_pulse}, 4'b0001);
    $display("step sticky: flags=%b", flags);

    // Reset mid-RUN at counter=7, cmd_valid held through release
    ticks(7);
    reset = 1'b1; tick();
    check("midrun_reset_flags", flags, 4'b0000);
    tick();
    reset = 1'b0; tick();
    check("release_start", {3'b000, start_pulse}, 4'b0001);
    check("release_busy", flags, 4'b0100);
    tick();
    check("release_start_once", {3'b000, start_pulse}, 4'b0000);
    $display("step reset_release: flags=%b", flags);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 11) == 0) cmd_valid = ~cmd_valid;
      core_done  = ($urandom_range(0, 9) == 0);
      core_error = ($urandom_range(0, 24) == 0);
      tick();
    end
    $display("step random: 3000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
